// File: rtl/btn_debounce.sv
// Button conditioner: synchronizer chain plus counter-qualified debounce FSM.
// Emits a clean level and one-cycle rise/fall pulses aligned with it.
module btn_debounce #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 1000000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } state_t;

  localparam state_t RST_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s_sync;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             level_n, rise_n, fall_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign s_sync = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_STATE;
      cnt       <= '0;
      btn_level <= RESET_LEVEL;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      btn_level <= level_n;
      btn_rise  <= rise_n;
      btn_fall  <= fall_n;
    end
  end

  // Pulses are computed here so they register in the same edge as the level.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    level_n = btn_level;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      STABLE_LO: begin
        if (s_sync) begin
          state_n = WAIT_HI;
          cnt_n   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!s_sync) begin
          state_n = STABLE_LO;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          state_n = STABLE_HI;
          cnt_n   = '0;
          level_n = 1'b1;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!s_sync) begin
          state_n = WAIT_LO;
          cnt_n   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (s_sync) begin
          state_n = STABLE_HI;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          state_n = STABLE_LO;
          cnt_n   = '0;
          level_n = 1'b0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = RST_STATE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    busy = (state == WAIT_HI) || (state == WAIT_LO);
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Randomized bench for btn_debounce with a run-length reference model.
// Directed scenarios cover reset, press, bounce, release and chaining.
module tb_btn_debounce;

  localparam int SYNC = 2;
  localparam int DC   = 4;

  logic clk = 1'b0;
  logic rst;
  logic btn_raw;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;
  logic busy;

  int checks = 0;
  int errors = 0;

  btn_debounce #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DC),
    .RESET_LEVEL    (1'b0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a level flips once DC consecutive synchronized samples disagree with it.
  logic m_pipe [SYNC];
  int   m_run   = 0;
  logic m_level = 1'b0;
  logic m_rise  = 1'b0;
  logic m_fall  = 1'b0;
  logic m_en    = 1'b0;

  always @(posedge clk) begin
    logic s;
    if (rst) begin
      for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
      m_run   = 0;
      m_level = 1'b0;
      m_rise  = 1'b0;
      m_fall  = 1'b0;
      m_en    = 1'b1;
    end else begin
      s = m_pipe[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = btn_raw;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s == m_level) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == DC) begin
          m_level = s;
          m_rise  = s;
          m_fall  = !s;
          m_run   = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_en) begin
      check("m_level", 32'(btn_level), 32'(m_level));
      check("m_rise", 32'(btn_rise), 32'(m_rise));
      check("m_fall", 32'(btn_fall), 32'(m_fall));
      check("m_busy", 32'(busy), 32'(m_run != 0));
    end
  end

  // Stand-in for the downstream rising-edge detector plus pulse counters.
  logic det_d = 1'b0;
  int   n_ped = 0;
  int   n_rise = 0;
  int   n_fall = 0;

  always @(posedge clk) begin
    if (btn_level === 1'b1 && det_d === 1'b0) n_ped++;
    if (btn_rise === 1'b1) n_rise++;
    if (btn_fall === 1'b1) n_fall++;
    det_d <= btn_level;
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int p0, r0, f0, hold;

    rst     = 1'b1;
    btn_raw = 1'b1;

    // T1: reset values with raw held high
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("t1_level", 32'(btn_level), 0);
      check("t1_rise", 32'(btn_rise), 0);
      check("t1_fall", 32'(btn_fall), 0);
      check("t1_busy", 32'(busy), 0);
    end
    rst = 1'b0;
    cyc(5);
    check("t1_pre", 32'(btn_level), 0);
    cyc(1);
    check("t1_level_up", 32'(btn_level), 1);
    check("t1_rise_up", 32'(btn_rise), 1);
    cyc(1);
    check("t1_rise_end", 32'(btn_rise), 0);

    btn_raw = 1'b0;
    cyc(10);
    check("t1_settle", 32'(btn_level), 0);

    // T2: clean press, edge k is the next posedge
    btn_raw = 1'b1;
    cyc(2);
    check("t2_busy_k1", 32'(busy), 0);
    for (int i = 2; i <= 4; i++) begin
      cyc(1);
      check("t2_busy", 32'(busy), 1);
      check("t2_level_lo", 32'(btn_level), 0);
    end
    cyc(1);
    check("t2_level", 32'(btn_level), 1);
    check("t2_rise", 32'(btn_rise), 1);
    check("t2_busy_off", 32'(busy), 0);
    cyc(1);
    check("t2_rise_end", 32'(btn_rise), 0);
    cyc(4);

    // T3: bounce shorter than the qualification window
    f0 = n_fall;
    btn_raw = 1'b0; cyc(2);
    btn_raw = 1'b1; cyc(1);
    btn_raw = 1'b0; cyc(3);
    btn_raw = 1'b1; cyc(8);
    check("t3_level", 32'(btn_level), 1);
    check("t3_nofall", 32'(n_fall - f0), 0);

    // T4: clean release
    btn_raw = 1'b0;
    cyc(5);
    check("t4_pre", 32'(btn_level), 1);
    cyc(1);
    check("t4_level", 32'(btn_level), 0);
    check("t4_fall", 32'(btn_fall), 1);
    cyc(1);
    check("t4_fall_end", 32'(btn_fall), 0);
    cyc(4);

    // T5: reset while qualifying with cnt=2
    btn_raw = 1'b1;
    cyc(4);
    check("t5_busy", 32'(busy), 1);
    rst = 1'b1;
    cyc(1);
    check("t5_level", 32'(btn_level), 0);
    check("t5_busy_off", 32'(busy), 0);
    check("t5_rise", 32'(btn_rise), 0);
    check("t5_fall", 32'(btn_fall), 0);
    rst     = 1'b0;
    btn_raw = 1'b0;
    cyc(10);

    // T6: five bouncy presses through the edge detector
    p0 = n_ped; r0 = n_rise; f0 = n_fall;
    for (int n = 0; n < 5; n++) begin
      for (int b = 0; b < int'($urandom_range(3, 0)); b++) begin
        btn_raw = ~btn_raw; cyc(1);
      end
      btn_raw = 1'b1; cyc(12);
      for (int b = 0; b < int'($urandom_range(3, 0)); b++) begin
        btn_raw = ~btn_raw; cyc(1);
      end
      btn_raw = 1'b0; cyc(12);
    end
    check("t6_ped", 32'(n_ped - p0), 5);
    check("t6_rise", 32'(n_rise - r0), 5);
    check("t6_fall", 32'(n_fall - f0), 5);

    // Random runs of mixed length with occasional resets
    for (int i = 0; i < 400; i++) begin
      btn_raw = 1'($urandom_range(1, 0));
      hold = int'($urandom_range(8, 1));
      if ($urandom_range(40, 0) == 0) rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      if (hold > 1) cyc(hold - 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
